// File: rtl/bram_readback_engine.sv
// bram_readback_engine: sequential port-B read master for a TDP_RAM36K, streaming packed 36-bit words with LAST.
// Optional CHECKSUM output (XOR of streamed words) when READBACK_CHECKSUM_EN is defined.
module bram_readback_engine #(
  parameter int READ_WIDTH = 36
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [14:0] BASE_IDX,
  input  logic [15:0] WORD_COUNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        REN,
  output logic [14:0] ADDR,
  input  logic [31:0] RDATA,
  input  logic [3:0]  RPARITY,
  output logic [35:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        DOUT_LAST
`ifdef READBACK_CHECKSUM_EN
  ,
  output logic [35:0] CHECKSUM
`endif
);
  localparam int ADDR_SHIFT = READ_WIDTH == 36 ? 5 : READ_WIDTH == 18 ? 4 : READ_WIDTH == 9 ? 3 :
                              READ_WIDTH == 4 ? 2 : READ_WIDTH == 2 ? 1 : 0;
  localparam int DEPTH = 32768 >> ADDR_SHIFT;
  localparam logic [14:0] IDX_MASK = 15'(DEPTH - 1);

  if (READ_WIDTH != 1 && READ_WIDTH != 2 && READ_WIDTH != 4 && READ_WIDTH != 9 &&
      READ_WIDTH != 18 && READ_WIDTH != 36) begin : g_bad_width
    $error("bram_readback_engine: illegal READ_WIDTH %0d", READ_WIDTH);
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [14:0] idx, rd_idx;
  logic [15:0] left;
  logic pend, pend_last, done, done_nx;
  logic [36:0] mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic [2:0] occ;
  logic abort_x, pop, start_ok, ren_run, rd_last;
  logic [35:0] pack_word;

  assign pack_word = READ_WIDTH == 36 ? {RPARITY, RDATA}
                   : READ_WIDTH == 18 ? {18'd0, RPARITY[1:0], RDATA[15:0]}
                   : READ_WIDTH == 9  ? {27'd0, RPARITY[0], RDATA[7:0]}
                   : {4'd0, RDATA & ((32'd1 << READ_WIDTH) - 32'd1)};
  assign BUSY = state != IDLE;
  assign DONE = done;
  assign DOUT = mem[rd_ptr][35:0];
  assign DOUT_VALID = cnt != 2'd0;
  assign DOUT_LAST = DOUT_VALID && mem[rd_ptr][36];

  // The first read goes out in the START acceptance cycle so DOUT_VALID lands two cycles after START.
  always_comb begin
    abort_x = ABORT && state != IDLE;
    pop = DOUT_VALID && DOUT_READY && !abort_x;
    occ = {1'b0, cnt} - {2'b0, pop} + {2'b0, pend};
    start_ok = state == IDLE && START;
    ren_run = state == RUN && !abort_x && occ < 3'd2;
    REN = RESET_N && ((start_ok && WORD_COUNT != 16'd0) || ren_run);
    rd_idx = state == IDLE ? BASE_IDX & IDX_MASK : idx;
    ADDR = REN ? 15'(rd_idx << ADDR_SHIFT) : 15'd0;
    rd_last = state == IDLE ? WORD_COUNT == 16'd1 : left == 16'd1;
    state_nx = abort_x ? IDLE
             : state == IDLE ? (START ? (WORD_COUNT < 16'd2 ? DRAIN : RUN) : IDLE)
             : state == RUN ? (ren_run && left == 16'd1 ? DRAIN : RUN)
             : ((pop && DOUT_LAST) || (cnt == 2'd0 && !pend)) ? IDLE : DRAIN;
    done_nx = state == DRAIN && !abort_x && state_nx == IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      done <= 1'b0;
      idx <= '0;
      left <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      mem <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      done <= done_nx;
      if (start_ok) begin
        idx <= (BASE_IDX + 15'd1) & IDX_MASK;
        left <= WORD_COUNT - 16'd1;
      end else if (ren_run) begin
        idx <= (idx + 15'd1) & IDX_MASK;
        left <= left - 16'd1;
      end
      pend <= !abort_x && ((start_ok && WORD_COUNT != 16'd0) || ren_run);
      pend_last <= rd_last;
      // ABORT flushes the FIFO and drops any read still in flight.
      if (abort_x) begin
        cnt <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (pend) begin
          mem[wr_ptr] <= {pend_last, pack_word};
          wr_ptr <= !wr_ptr;
        end
        if (pop) rd_ptr <= !rd_ptr;
        cnt <= cnt + {1'b0, pend} - {1'b0, pop};
      end
    end
  end

`ifdef READBACK_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) CHECKSUM <= '0;
    else if (start_ok) CHECKSUM <= '0;
    else if (pop) CHECKSUM <= CHECKSUM ^ DOUT;
  end
`endif
endmodule

// File: tb/tb_bram_readback_engine.sv
// tb_bram_readback_engine: width-36 and width-9 engines driven together, each checked every cycle against a queue model.
`timescale 1ns/1ps
module tb_bram_readback_engine;
  logic CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, ABORT = 1'b0, DOUT_READY = 1'b1;
  logic [14:0] BASE_IDX = '0;
  logic [15:0] WORD_COUNT = '0;
  logic busy[2], done[2], ren[2], valid[2], last[2];
  logic [14:0] addr[2];
  logic [35:0] dout[2];
`ifdef READBACK_CHECKSUM_EN
  logic [35:0] csum[2];
`endif
  int tests = 0, fails = 0, cyc = 0, pat_mode = 0;
  int addr_n[2], dout_n[2], start_cyc[2], fv_cyc[2], done_cyc[2];
  logic [14:0] addr_log[2][16];
  logic [35:0] dout_log[2][16];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM contents as {parity, data} for word index k.
  function automatic logic [35:0] bram_word(int w, int k);
    if (pat_mode != 0) return {4'h0, 32'd1 << k};
    return w == 36 ? {4'h9, 32'(k)} : {4'h5, 32'hCAFE_0000 | 32'(k)};
  endfunction

  function automatic logic [35:0] pack(int w, logic [35:0] r);
    logic [35:0] m;
    m = (36'd1 << w) - 36'd1;
    return w == 36 ? r : w == 18 ? {18'd0, r[33:32], r[15:0]} : w == 9 ? {27'd0, r[32], r[7:0]} : r & m;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int W = g == 0 ? 36 : 9;
    localparam int SH = W == 36 ? 5 : 3;
    localparam int DEPTH = 32768 >> SH;
    logic [31:0] rdata = '0;
    logic [3:0] rpar = '0;
    bram_readback_engine #(.READ_WIDTH(W)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
      .BASE_IDX(BASE_IDX), .WORD_COUNT(WORD_COUNT), .BUSY(busy[g]), .DONE(done[g]),
      .REN(ren[g]), .ADDR(addr[g]), .RDATA(rdata), .RPARITY(rpar),
      .DOUT(dout[g]), .DOUT_VALID(valid[g]), .DOUT_READY(DOUT_READY), .DOUT_LAST(last[g])
`ifdef READBACK_CHECKSUM_EN
      , .CHECKSUM(csum[g])
`endif
    );
    always @(posedge CLK) if (ren[g]) {rpar, rdata} <= bram_word(W, int'(addr[g]) >> SH);

    logic [35:0] exp_q[$];
    logic exp_last_q[$];
    logic [14:0] addr_q[$];
    int buf_cnt = 0;
    logic ren_prev = 1'b0, m_busy = 1'b0, m_done = 1'b0, zero_pend = 1'b0, stall = 1'b0;
    logic [35:0] prev_dout = '0, m_sum = '0;
    logic prev_last = 1'b0;
    always @(negedge CLK) begin
      logic hs, nb, nd, ab;
      int k;
      if (!RESET_N) begin
        exp_q.delete(); exp_last_q.delete(); addr_q.delete();
        buf_cnt = 0; ren_prev = 1'b0; m_busy = 1'b0; m_done = 1'b0; zero_pend = 1'b0; stall = 1'b0;
      end else begin
        chk($sformatf("w%0d_busy", W), 36'(busy[g]), 36'(m_busy));
        chk($sformatf("w%0d_done", W), 36'(done[g]), 36'(m_done));
        chk($sformatf("w%0d_valid", W), 36'(valid[g]), 36'(buf_cnt != 0));
`ifdef READBACK_CHECKSUM_EN
        if (m_done) chk($sformatf("w%0d_checksum", W), csum[g], m_sum);
`endif
        if (done[g]) done_cyc[g] = cyc;
        if (valid[g] && fv_cyc[g] < 0) fv_cyc[g] = cyc;
        nb = m_busy; nd = 1'b0;
        ab = ABORT && m_busy;
        if (!m_busy && START) begin
          start_cyc[g] = cyc; fv_cyc[g] = -1; m_sum = '0;
          for (int i = 0; i < int'(WORD_COUNT); i++) begin
            k = (int'(BASE_IDX) + i) % DEPTH;
            addr_q.push_back(15'(k << SH));
            exp_q.push_back(pack(W, bram_word(W, k)));
            exp_last_q.push_back(i == int'(WORD_COUNT) - 1);
          end
          nb = 1'b1; zero_pend = WORD_COUNT == 16'd0;
        end else if (zero_pend && !ab) begin
          nd = 1'b1; nb = 1'b0; zero_pend = 1'b0;
        end
        if (ren[g]) begin
          if (addr_q.size() == 0) chk($sformatf("w%0d_ren_unexpected", W), 36'd1, 36'd0);
          else begin
            chk($sformatf("w%0d_addr", W), 36'(addr[g]), 36'(addr_q[0]));
            void'(addr_q.pop_front());
            if (addr_n[g] < 16) addr_log[g][addr_n[g]] = addr[g];
            addr_n[g]++;
          end
        end
        hs = valid[g] && DOUT_READY && !ab;
        if (ren[g]) chk($sformatf("w%0d_credit", W), 36'((buf_cnt - int'(hs) + int'(ren_prev)) < 2), 36'd1);
        if (hs) begin
          if (exp_q.size() == 0) chk($sformatf("w%0d_extra_word", W), 36'd1, 36'd0);
          else begin
            chk($sformatf("w%0d_dout", W), dout[g], exp_q[0]);
            chk($sformatf("w%0d_last", W), 36'(last[g]), 36'(exp_last_q[0]));
            if (dout_n[g] < 16) dout_log[g][dout_n[g]] = dout[g];
            dout_n[g]++;
            m_sum ^= exp_q[0];
            if (exp_last_q[0]) begin nd = 1'b1; nb = 1'b0; end
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
          end
        end
        if (stall) begin
          chk($sformatf("w%0d_hold_dout", W), dout[g], prev_dout);
          chk($sformatf("w%0d_hold_last", W), 36'(last[g]), 36'(prev_last));
        end
        stall = valid[g] && !DOUT_READY && !ab;
        prev_dout = dout[g]; prev_last = last[g];
        if (ab) begin
          exp_q.delete(); exp_last_q.delete(); addr_q.delete();
          nb = 1'b0; nd = 1'b0; zero_pend = 1'b0;
        end
        buf_cnt = ab ? 0 : buf_cnt + int'(ren_prev) - int'(hs);
        ren_prev = ren[g] && !ab;
        m_busy = nb; m_done = nd;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // mode 0: ready high; 1: ready 1010.. then low 20 cycles; 2: ready high plus a START while busy
  task automatic run(input int base, input int cnt, input int mode);
    BASE_IDX = 15'(base); WORD_COUNT = 16'(cnt);
    addr_n = '{0, 0}; dout_n = '{0, 0};
    DOUT_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 300 && !done[0]; i++) begin
      DOUT_READY = mode != 1 ? 1'b1 : i < 8 ? i % 2 == 0 : i >= 28;
      START = mode == 2 && i == 1;
      if (mode == 2 && i == 1) BASE_IDX = 15'd500;
      tick();
    end
    START = 1'b0;
    chk("done_reached", 36'(done[0]), 36'd1);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin fv_cyc[i] = -1; done_cyc[i] = 0; start_cyc[i] = 0; end
    START = 1'b1;
    #2;
    for (int g = 0; g < 2; g++) begin
      chk("reset_ctl", 36'({busy[g], done[g], ren[g], valid[g], last[g], addr[g]}), 36'd0);
      chk("reset_dout", dout[g], 36'd0);
    end
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    tick();

    run(0, 4, 2);
    chk("t1_addr0", 36'(addr_log[0][0]), 36'd0);
    chk("t1_addr1", 36'(addr_log[0][1]), 36'd32);
    chk("t1_addr2", 36'(addr_log[0][2]), 36'd64);
    chk("t1_addr3", 36'(addr_log[0][3]), 36'd96);
    chk("t1_dout0", dout_log[0][0], 36'h9_0000_0000);
    chk("t1_dout3", dout_log[0][3], 36'h9_0000_0003);
    chk("t1_w9_dout1", dout_log[1][1], 36'h0_0000_0101);
    chk("t1_first_valid_lat", 36'(fv_cyc[0] - start_cyc[0]), 36'd2);
    chk("t1_words", 36'(dout_n[0]), 36'd4);

    run(1022, 3, 0);
    chk("t2_addr0", 36'(addr_log[0][0]), 36'd32704);
    chk("t2_addr1", 36'(addr_log[0][1]), 36'd32736);
    chk("t2_addr2", 36'(addr_log[0][2]), 36'd0);

    run(16, 8, 1);
    chk("t3_words", 36'(dout_n[1]), 36'd8);
    chk("t3_w9_dout7", dout_log[1][7], 36'h0_0000_117);

    run(5, 0, 0);
    chk("t4_no_ren", 36'(addr_n[0]), 36'd0);
    chk("t4_done_lat", 36'(done_cyc[0] - start_cyc[0]), 36'd2);

    BASE_IDX = 15'd40; WORD_COUNT = 16'd10; dout_n = '{0, 0};
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 50 && dout_n[0] < 2; i++) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t5_accepted", 36'(dout_n[0]), 36'd2);
    chk("t5_ren", 36'(ren[0]), 36'd0);
    chk("t5_valid", 36'(valid[0]), 36'd0);
    chk("t5_busy", 36'(busy[0]), 36'd0);
    tick();
    chk("t5_no_done", 36'(done[0]), 36'd0);
    tick();
    run(100, 3, 0);
    chk("t5_restart_dout0", dout_log[0][0], 36'h9_0000_0064);

    pat_mode = 1;
    run(0, 3, 0);
    pat_mode = 0;
    chk("t6_dout2", dout_log[0][2], 36'h4);
`ifdef READBACK_CHECKSUM_EN
    chk("t6_checksum", csum[0], 36'h7);
`endif

    BASE_IDX = 15'd0; WORD_COUNT = 16'd20; DOUT_READY = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    chk("t7_pre_busy", 36'(busy[0]), 36'd1);
    #2 RESET_N = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("t7_reset_ctl", 36'({busy[g], done[g], ren[g], valid[g], last[g], addr[g]}), 36'd0);
      chk("t7_reset_dout", dout[g], 36'd0);
    end
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1; DOUT_READY = 1'b1;
    repeat (3) tick();
    chk("t7_idle_after", 36'({busy[0], done[0]}), 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
